// File: rtl/space_pkg.sv
// Shared enemy encodings: kind codes, weapon/kind damage factors, kill points, slot states.
// Pure definitions, no logic; latency and backpressure not applicable.
package space_pkg;

  typedef enum logic [1:0] {
    KIND_0 = 2'd0,
    KIND_1 = 2'd1,
    KIND_2 = 2'd2
  } kind_e;

  localparam logic [3:0] FIRE0_DMG = 4'd2;
  localparam logic [3:0] FIRE1_DMG = 4'd1;

  localparam logic [3:0] KIND0_DMG = 4'd4;
  localparam logic [3:0] KIND1_DMG = 4'd2;
  localparam logic [3:0] KIND2_DMG = 4'd1;

  localparam logic [2:0] KIND0_PTS = 3'd1;
  localparam logic [2:0] KIND1_PTS = 3'd2;
  localparam logic [2:0] KIND2_PTS = 3'd4;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_DYING  = 2'd2
  } slot_state_e;

  // The unused kind code 3 is folded onto kind 0 at spawn.
  function automatic logic [1:0] kind_norm(input logic [1:0] k);
    return (k == 2'd3) ? 2'd0 : k;
  endfunction

  function automatic logic [3:0] hit_damage(input logic mode, input logic [1:0] kind);
    logic [3:0] fd;
    logic [3:0] kd;
    fd = mode ? FIRE1_DMG : FIRE0_DMG;
    case (kind)
      KIND_1:  kd = KIND1_DMG;
      KIND_2:  kd = KIND2_DMG;
      default: kd = KIND0_DMG;
    endcase
    return fd * kd;
  endfunction

  function automatic logic [2:0] kill_points(input logic [1:0] kind);
    case (kind)
      KIND_1:  return KIND1_PTS;
      KIND_2:  return KIND2_PTS;
      default: return KIND0_PTS;
    endcase
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: IDLE -> ACTIVE on load, ACTIVE -> DYING on kill/collision, DYING -> IDLE.
// State updates one cycle after inputs are sampled; no backpressure, load is honoured only in IDLE.
module enemy_slot
  import space_pkg::*;
#(
  parameter int DIST_W     = 8,
  parameter int SPAWN_DIST = 200,
  parameter int HIT_DIST   = 8,
  parameter int HEALTH_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [3:0]        new_angle,
  input  logic [1:0]        new_kind,
  input  logic              tick,
  input  logic              firing,
  input  logic [15:0]       angles_hit,
  input  logic              mode,
  output logic              idle,
  output logic              alive,
  output logic [3:0]        angle,
  output logic [1:0]        kind,
  output logic [DIST_W-1:0] distance,
  output logic [3:0]        health,
  output logic              kill_pulse,
  output logic              collision_pulse
);

  slot_state_e state;
  logic        hit;
  logic [3:0]  dmg;
  logic [3:0]  hit_health;
  logic        at_player;

  assign hit        = firing & angles_hit[angle];
  assign dmg        = hit_damage(mode, kind);
  assign hit_health = (health > dmg) ? (health - dmg) : 4'd0;
  assign at_player  = (distance == DIST_W'(HIT_DIST));
  assign idle       = (state == SLOT_IDLE);
  assign alive      = ~idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SLOT_IDLE;
      angle           <= 4'd0;
      kind            <= 2'd0;
      distance        <= '0;
      health          <= 4'(HEALTH_MAX);
      kill_pulse      <= 1'b0;
      collision_pulse <= 1'b0;
    end else begin
      kill_pulse      <= 1'b0;
      collision_pulse <= 1'b0;
      case (state)
        SLOT_IDLE: begin
          if (load) begin
            state    <= SLOT_ACTIVE;
            angle    <= new_angle;
            kind     <= new_kind;
            distance <= DIST_W'(SPAWN_DIST);
            health   <= 4'(HEALTH_MAX);
          end
        end
        SLOT_ACTIVE: begin
          // Reaching the player takes priority over any hit landing this cycle.
          if (at_player) begin
            state           <= SLOT_DYING;
            health          <= 4'd0;
            collision_pulse <= 1'b1;
          end else begin
            if (tick && (distance > DIST_W'(HIT_DIST))) begin
              distance <= distance - DIST_W'(1);
            end
            if (hit) begin
              health <= hit_health;
              if (hit_health == 4'd0) begin
                state      <= SLOT_DYING;
                kill_pulse <= 1'b1;
              end
            end
          end
        end
        SLOT_DYING: begin
          state  <= SLOT_IDLE;
          health <= 4'(HEALTH_MAX);
        end
        default: state <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/enemy_pool.sv
// Enemy slot pool: tick divider, lowest-free-slot spawn allocator, packed per-slot outputs; optional score via ENEMY_POOL_SCORE_EN.
// Slot state valid one cycle after spawn/fire; spawn_ack is combinational, spawns with no free slot are dropped.
module enemy_pool
  import space_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int DIST_W     = 8,
  parameter int SPAWN_DIST = 200,
  parameter int HIT_DIST   = 8,
  parameter int TICK_COUNT = 3125000,
  parameter int HEALTH_MAX = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spawn,
  input  logic [3:0]                 new_angle,
  input  logic [1:0]                 new_kind,
  output logic                       spawn_ack,
  input  logic [15:0]                angles_hit,
  input  logic                       firing,
  input  logic                       mode,
  output logic [N_SLOTS-1:0]         alive,
  output logic [4*N_SLOTS-1:0]       angle,
  output logic [2*N_SLOTS-1:0]       kind,
  output logic [DIST_W*N_SLOTS-1:0]  distance,
  output logic [4*N_SLOTS-1:0]       health,
  output logic [N_SLOTS-1:0]         kill_pulse,
  output logic [N_SLOTS-1:0]         collision_pulse
`ifdef ENEMY_POOL_SCORE_EN
  ,
  output logic [15:0]                score
`endif
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [N_SLOTS-1:0] idle_vec;
  logic [N_SLOTS-1:0] grant;
  logic               found;
  logic [1:0]         spawn_kind;

  assign tick       = (tick_cnt == CNT_W'(TICK_COUNT - 1));
  assign spawn_ack  = spawn & (|idle_vec);
  assign spawn_kind = kind_norm(new_kind);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // One-hot grant to the lowest-index IDLE slot.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (idle_vec[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    enemy_slot #(
      .DIST_W     (DIST_W),
      .SPAWN_DIST (SPAWN_DIST),
      .HIT_DIST   (HIT_DIST),
      .HEALTH_MAX (HEALTH_MAX)
    ) u_slot (
      .clk             (clk),
      .rst_n           (rst_n),
      .load            (spawn & grant[i]),
      .new_angle       (new_angle),
      .new_kind        (spawn_kind),
      .tick            (tick),
      .firing          (firing),
      .angles_hit      (angles_hit),
      .mode            (mode),
      .idle            (idle_vec[i]),
      .alive           (alive[i]),
      .angle           (angle[4*i +: 4]),
      .kind            (kind[2*i +: 2]),
      .distance        (distance[DIST_W*i +: DIST_W]),
      .health          (health[4*i +: 4]),
      .kill_pulse      (kill_pulse[i]),
      .collision_pulse (collision_pulse[i])
    );
  end

`ifdef ENEMY_POOL_SCORE_EN
  logic [6:0]  kill_pts;
  logic [16:0] score_sum;

  always_comb begin
    kill_pts = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (kill_pulse[i]) begin
        kill_pts = kill_pts + 7'(kill_points(kind[2*i +: 2]));
      end
    end
  end

  assign score_sum = {1'b0, score} + 17'(kill_pts);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= 16'd0;
    end else begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`endif

endmodule
